rect_blitter: RTL and testbench
===============================

Name: rect_blitter

Overview:
- Command-driven rectangle rasterizer between the game FSM and vga_adapter.
- Game logic enqueues filled-rectangle draw commands (x, y, w, h, colour). The block emits one pixel per clock on the x/y/colour/plot interface of the 160x120 vga_adapter.
- Replaces the per-state draw_counter loops: background clear, paddle draw/erase and ball draw/erase all become single commands.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- FIFO_DEPTH, 4, command queue entries (power of two)
- COLOUR_W, 3, colour bits (1 bit per channel)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept a command
- cmd_x  in  8  top-left x
- cmd_y  in  8  top-left y
- cmd_w  in  8  width in pixels, 0 allowed
- cmd_h  in  8  height in pixels, 0 allowed
- cmd_colour  in  COLOUR_W  fill colour
- x  out  8  pixel x to vga_adapter
- y  out  8  pixel y to vga_adapter
- colour  out  COLOUR_W  pixel colour
- plot  out  1  write enable to vga_adapter
- cmd_done  out  1  one-cycle pulse when a command's last pixel cycle issues
- busy  out  1  high while FIFO non-empty or drawing

Behaviour:
- Reset (synchronous, resetn=0 at clk edge):
  - FIFO emptied; FSM goes to IDLE.
  - Outputs: plot=0, cmd_done=0, busy=0, x=0, y=0, colour=0.
  - cmd_ready=1 from the first cycle after reset.
  - Reset mid-draw abandons the rectangle; no further plots.
- Handshake:
  - Accept when cmd_valid && cmd_ready at a rising edge.
  - cmd_ready = !full. Push is refused when full even if a pop occurs in the same cycle.
  - Command fields are sampled only on the accepting edge.
- FSM: IDLE, DRAW.
  - IDLE: if FIFO non-empty, pop and load working registers (x0, y0, w, h, colour, col=0, row=0).
    - w and h both non-zero: go to DRAW with plot=1 and the first pixel (x0, y0) registered.
    - w==0 or h==0: pulse cmd_done with plot=0 and stay in IDLE.
  - DRAW: one pixel per cycle in row-major order: col 0..w-1, then row+1.
    - Outputs are registered: x = x0+col, y = y0+row (8-bit, modulo 256).
    - On the last pixel (col==w-1, row==h-1), cmd_done=1 in the same cycle as that pixel's plot.
    - After the last pixel: if FIFO non-empty, pop in that cycle so the next command's first pixel follows with no bubble; a zero-size next command pulses cmd_done with plot=0 for one cycle. If FIFO empty, return to IDLE with plot=0.
- Timing:
  - Latency: accept on edge of cycle 0, pop in cycle 1, first plot in cycle 2.
  - A w*h rectangle occupies exactly w*h plot cycles.
- busy = FIFO non-empty || state==DRAW.
- Pixel counters: col and row are 8 bits. The 160x120 clear (19200 pixels) must complete without counter overflow.
- Colour is held constant for the whole rectangle.

Optional Feature:
- Macro: RECT_BLITTER_CLIP_EN.
- Defined: a pixel with x0+col >= SCREEN_W or y0+row >= SCREEN_H (compared in 9-bit unwrapped sums) has plot=0. Its cycle is still consumed, so timing and cmd_done position are identical to the unclipped build.
- Undefined: every pixel cycle asserts plot; coordinates wrap modulo 256.

Decomposition:
- Package blit_pkg: SCREEN_W, SCREEN_H, COLOUR_W, command field widths, packed command type {x, y, w, h, colour} (35 bits), FSM state encoding.
- Sub-module cmd_fifo: synchronous FIFO, FIFO_DEPTH x command width, with push/pop/full/empty and synchronous active-low reset. The rasterizer FSM and counters stay in rect_blitter.

Test Plan:
- Reset, then cmd (72,110,12,2,7) -> 24 plots.
  - First pixel (72,110) in cycle 2 after accept; last (83,111) with cmd_done=1.
  - busy=0 the cycle after.
- cmd (10,10,0,5,3) -> zero plots; one cmd_done pulse; busy returns 0.
- Six 2x2 commands with cmd_valid held high -> cmd_ready low while 4 queued.
  - 24 consecutive plot cycles with no gaps.
  - Six cmd_done pulses, on plot cycles 4, 8, 12, 16, 20, 24.
- Full clear (0,0,160,120,0) -> 19200 plots; last (159,119); no counter wrap.
- Reset asserted on the 5th pixel of a 12x2 draw -> plot=0 next cycle, cmd_ready=1, FIFO empty, no further plots.
- cmd (158,0,4,1,5):
  - RECT_BLITTER_CLIP_EN defined: plot=1 at x=158,159; plot=0 at x=160,161; cmd_done on the 4th cycle.
  - RECT_BLITTER_CLIP_EN undefined: 4 plots, x=158..161.

Source files
------------

// File: rtl/rect_blitter_pkg.sv
// Shared types and constants for the rectangle blitter: screen size, the
// packed draw command and the rasterizer state encoding.
package blit_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int COLOUR_W   = 3;
  localparam int COORD_W    = 8;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COORD_W-1:0]  w;
    logic [COORD_W-1:0]  h;
    logic [COLOUR_W-1:0] colour;
  } blit_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } blit_state_t;

  // Unwrapped 9-bit sums so a pixel that runs off the edge never wraps back on screen.
  function automatic logic pix_in_screen(input logic [COORD_W-1:0] x0,
                                         input logic [COORD_W-1:0] col,
                                         input logic [COORD_W-1:0] y0,
                                         input logic [COORD_W-1:0] row);
    logic [COORD_W:0] xs;
    logic [COORD_W:0] ys;
    xs = {1'b0, x0} + {1'b0, col};
    ys = {1'b0, y0} + {1'b0, row};
    return (xs < 9'(SCREEN_W)) && (ys < 9'(SCREEN_H));
  endfunction

endpackage

// File: rtl/rect_blitter_if.sv
// Command and pixel bus of the rectangle blitter; master is the game side,
// slave is the blitter itself.
interface rect_blitter_if;
  import blit_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [COORD_W-1:0]  cmd_x;
  logic [COORD_W-1:0]  cmd_y;
  logic [COORD_W-1:0]  cmd_w;
  logic [COORD_W-1:0]  cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                cmd_done;
  logic                busy;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready, x, y, colour, plot, cmd_done, busy
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output cmd_ready, x, y, colour, plot, cmd_done, busy
  );

endinterface

// File: rtl/rect_blitter_cmd_fifo.sv
// Synchronous command queue. A push while full is dropped even when a pop
// happens in the same cycle, so the producer only ever sees !full as ready.
module cmd_fifo
  import blit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      push,
  input  logic      pop,
  input  blit_cmd_t wr_data,
  output blit_cmd_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  blit_cmd_t      mem_q [DEPTH];
  blit_cmd_t      mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rect_blitter.sv
// Filled-rectangle rasterizer feeding one pixel per clock to the 160x120 VGA
// adapter. Define RECT_BLITTER_CLIP_EN to suppress plot for off-screen pixels.
module rect_blitter
  import blit_pkg::*;
#(
  parameter int FIFO_DEPTH = blit_pkg::FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           resetn,
  rect_blitter_if.slave  bus
);

  blit_cmd_t   push_cmd, head_cmd;
  logic        fifo_full, fifo_empty, pop;

  blit_state_t         state_q, state_d;
  logic [COORD_W-1:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [COORD_W-1:0]  col_q, col_d, row_q, row_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d, done_q, done_d;
  logic                load, emit, last_pix;

  assign push_cmd = '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w, h: bus.cmd_h,
                      colour: bus.cmd_colour};

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (bus.cmd_valid),
    .pop     (pop),
    .wr_data (push_cmd),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign last_pix = (col_q == w_q - 8'd1) && (row_q == h_q - 8'd1);

  // Outputs are registered, so x/y/plot/done for a pixel are computed one
  // cycle ahead from the next counter values.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    row_d    = row_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    emit     = 1'b0;

    case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_DRAW: begin
        if (!last_pix) begin
          emit = 1'b1;
          if (col_q == w_q - 8'd1) begin
            col_d = '0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if ((head_cmd.w != '0) && (head_cmd.h != '0)) begin
        state_d  = ST_DRAW;
        emit     = 1'b1;
        x0_d     = head_cmd.x;
        y0_d     = head_cmd.y;
        w_d      = head_cmd.w;
        h_d      = head_cmd.h;
        col_d    = '0;
        row_d    = '0;
        colour_d = head_cmd.colour;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if (emit) begin
      x_d    = x0_d + col_d;
      y_d    = y0_d + row_d;
      done_d = (col_d == w_d - 8'd1) && (row_d == h_d - 8'd1);
`ifdef RECT_BLITTER_CLIP_EN
      plot_d = pix_in_screen(x0_d, col_d, y0_d, row_d);
`else
      plot_d = 1'b1;
`endif
    end
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.cmd_done  = done_q;
  assign bus.busy      = !fifo_empty || (state_q == ST_DRAW);

endmodule

// File: tb/tb_rect_blitter.sv
// Directed bench for rect_blitter: each step queues commands, runs a fixed
// number of cycles while tallying plots/done pulses, then checks the tallies.
module tb_rect_blitter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rect_blitter_if bus();

  rect_blitter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
    logic [7:0] h;
    logic [2:0] c;
  } tcmd_t;

  tcmd_t pend[$];
  int    checks = 0;
  int    errors = 0;
  int    n_plot, n_done, first_idx, first_x, first_y, done_x, done_y, done_idx;
  int    last_px, gaps, last_plot_idx, busy_after, ready_low;
  int    done_pos[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_cmd(input int x, input int y, input int w, input int h, input int c);
    tcmd_t t;
    t.x = 8'(x); t.y = 8'(y); t.w = 8'(w); t.h = 8'(h); t.c = 3'(c);
    pend.push_back(t);
  endtask

  task automatic present();
    if (pend.size() > 0) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_x      = pend[0].x;
      bus.cmd_y      = pend[0].y;
      bus.cmd_w      = pend[0].w;
      bus.cmd_h      = pend[0].h;
      bus.cmd_colour = pend[0].c;
    end else begin
      bus.cmd_valid  = 1'b0;
    end
  endtask

  // Sample index i is the i-th cycle after the edge that accepts the first command.
  task automatic collect(input int n);
    logic was_ready;
    logic prev_done;
    n_plot = 0; n_done = 0; first_idx = -1; first_x = -1; first_y = -1;
    done_x = -1; done_y = -1; done_idx = -1; last_px = -1; gaps = 0;
    last_plot_idx = 0; busy_after = -1; ready_low = 0;
    done_pos.delete();
    present();
    was_ready = bus.cmd_ready;
    prev_done = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.cmd_valid && was_ready) void'(pend.pop_front());
      if (prev_done) busy_after = int'(bus.busy);
      if (bus.plot) begin
        n_plot++;
        if (first_idx < 0) begin
          first_idx = i; first_x = int'(bus.x); first_y = int'(bus.y);
        end else if (i != last_plot_idx + 1) begin
          gaps++;
        end
        last_plot_idx = i;
        last_px = int'(bus.x);
      end
      if (bus.cmd_done) begin
        n_done++; done_x = int'(bus.x); done_y = int'(bus.y); done_idx = i;
        done_pos.push_back(n_plot);
      end
      prev_done = bus.cmd_done;
      present();
      if (bus.cmd_valid && !bus.cmd_ready) ready_low++;
      was_ready = bus.cmd_ready;
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_colour = '0;
    repeat (3) @(negedge clk);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_done", 32'(bus.cmd_done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_colour", 32'(bus.colour), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 1);

    // 12x2 at (72,110)
    add_cmd(72, 110, 12, 2, 7);
    collect(30);
    chk("r1_first_idx", 32'(first_idx), 2);
    chk("r1_first_x", 32'(first_x), 72);
    chk("r1_first_y", 32'(first_y), 110);
    chk("r1_plots", 32'(n_plot), 24);
    chk("r1_gaps", 32'(gaps), 0);
    chk("r1_dones", 32'(n_done), 1);
    chk("r1_done_at_plot", 32'(done_pos.size() > 0 ? done_pos[0] : -1), 24);
    chk("r1_last_x", 32'(done_x), 83);
    chk("r1_last_y", 32'(done_y), 111);
    chk("r1_colour", 32'(bus.colour), 7);
    chk("r1_busy_after", 32'(busy_after), 0);

    // zero width
    add_cmd(10, 10, 0, 5, 3);
    collect(6);
    chk("z_plots", 32'(n_plot), 0);
    chk("z_dones", 32'(n_done), 1);
    chk("z_done_idx", 32'(done_idx), 2);
    chk("z_busy_after", 32'(busy_after), 0);

    // six 2x2 back to back
    for (int k = 0; k < 6; k++) add_cmd(10 * k, 5 + k, 2, 2, k + 1);
    collect(34);
    chk("b_ready_low", 32'(ready_low > 0), 1);
    chk("b_plots", 32'(n_plot), 24);
    chk("b_first_idx", 32'(first_idx), 2);
    chk("b_gaps", 32'(gaps), 0);
    chk("b_dones", 32'(n_done), 6);
    for (int k = 0; k < done_pos.size(); k++) chk("b_done_pos", 32'(done_pos[k]), 32'(4 * (k + 1)));
    chk("b_last_x", 32'(done_x), 51);
    chk("b_last_y", 32'(done_y), 11);
    chk("b_busy_end", 32'(bus.busy), 0);

    // reset on the 5th pixel of a 12x2 draw, with a second command queued
    add_cmd(20, 30, 12, 2, 4);
    add_cmd(1, 1, 3, 3, 2);
    collect(6);
    chk("m_plots_before", 32'(n_plot), 5);
    chk("m_x_5th", 32'(bus.x), 24);
    resetn = 1'b0;
    @(negedge clk);
    chk("m_plot", 32'(bus.plot), 0);
    chk("m_ready", 32'(bus.cmd_ready), 1);
    chk("m_busy", 32'(bus.busy), 0);
    resetn = 1'b1;
    collect(20);
    chk("m_plots_after", 32'(n_plot), 0);
    chk("m_dones_after", 32'(n_done), 0);

    // right-edge straddle
    add_cmd(158, 0, 4, 1, 5);
    collect(10);
    chk("c_first_x", 32'(first_x), 158);
    chk("c_done_idx", 32'(done_idx), 5);
    chk("c_done_x", 32'(done_x), 161);
`ifdef RECT_BLITTER_CLIP_EN
    chk("c_plots", 32'(n_plot), 2);
    chk("c_last_plot_x", 32'(last_px), 159);
`else
    chk("c_plots", 32'(n_plot), 4);
    chk("c_last_plot_x", 32'(last_px), 161);
`endif

    // full-screen clear
    add_cmd(0, 0, 160, 120, 0);
    collect(19210);
    chk("f_plots", 32'(n_plot), 19200);
    chk("f_gaps", 32'(gaps), 0);
    chk("f_dones", 32'(n_done), 1);
    chk("f_last_x", 32'(done_x), 159);
    chk("f_last_y", 32'(done_y), 119);
    chk("f_busy_after", 32'(busy_after), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
